// File: rtl/pipe_ctrl.sv
// Pipeline control: jump redirect, external hold with deferred jump, load-use style hazard stall.
// Optional jump-flush event counter is built only when PERF_CNT_EN is defined.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_req_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_reg_wen_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic [1:0]  state_o,
  output logic [15:0] flush_cnt_o
);

  localparam logic [1:0] ST_INIT  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;
  localparam logic [1:0] ST_HOLD  = 2'b11;

  logic [1:0]  state_q, state_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        hazard;
  logic        stall_if_id_c;

  assign hazard = ex_reg_wen_i && (ex_rd_addr_i != 5'd0) &&
                  ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pend_addr_d   = pend_addr_q;
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'h0;
    stall_pc_o    = 1'b0;
    stall_if_id_c = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    case (state_q)
      ST_INIT: begin
        stall_pc_o    = 1'b1;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        state_d       = ST_RUN;
      end
      ST_RUN, ST_FLUSH: begin
        // The wrong-path fetch still sits in IF/ID during FLUSH, so it is always bubbled.
        flush_if_id_o = (state_q == ST_FLUSH);
        if (jump_en_i) begin
          jump_en_o     = 1'b1;
          jump_addr_o   = jump_addr_i;
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          state_d       = ST_FLUSH;
        end else if (hold_req_i) begin
          stall_pc_o    = 1'b1;
          stall_if_id_c = 1'b1;
          flush_id_ex_o = 1'b1;
          state_d       = ST_HOLD;
        end else if (hazard) begin
          stall_pc_o    = 1'b1;
          stall_if_id_c = 1'b1;
          flush_id_ex_o = 1'b1;
          state_d       = ST_RUN;
        end else begin
          state_d       = ST_RUN;
        end
      end
      default: begin // ST_HOLD
        if (hold_req_i) begin
          stall_pc_o    = 1'b1;
          stall_if_id_c = 1'b1;
          flush_id_ex_o = 1'b1;
          if (jump_en_i && !pend_q) begin
            pend_d      = 1'b1;
            pend_addr_d = jump_addr_i;
          end
        end else if (pend_q || jump_en_i) begin
          // The earliest jump seen during the hold is the architecturally correct one.
          jump_en_o     = 1'b1;
          jump_addr_o   = pend_q ? pend_addr_q : jump_addr_i;
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          pend_d        = 1'b0;
          pend_addr_d   = 32'h0;
          state_d       = ST_FLUSH;
        end else begin
          state_d       = ST_RUN;
        end
      end
    endcase
  end

  assign stall_if_id_o = stall_if_id_c & ~flush_if_id_o;
  assign state_o       = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      pend_q      <= 1'b0;
      pend_addr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (jump_en_o && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 16'h0;
    else        cnt_q <= cnt_d;
  end

  assign flush_cnt_o = cnt_q;
`else
  assign flush_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; control bundle is {jump_en, stall_pc, stall_if_id, flush_if_id, flush_id_ex, state}.
// Counter checks follow the PERF_CNT_EN build setting.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_req_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic        ex_reg_wen_i;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o;
  logic [1:0]  state_o;
  logic [15:0] flush_cnt_o;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_cnt = 16'h0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .hold_req_i(hold_req_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_reg_wen_i(ex_reg_wen_i),
    .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o), .stall_pc_o(stall_pc_o),
    .stall_if_id_o(stall_if_id_o), .flush_if_id_o(flush_if_id_o),
    .flush_id_ex_o(flush_id_ex_o), .state_o(state_o), .flush_cnt_o(flush_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Check outputs mid-cycle, then advance one clock.
  task automatic step(input string tag, input logic [6:0] exp_ctl, input logic [31:0] exp_addr);
    @(negedge clk);
    chk({tag, ".ctl"}, {25'h0, jump_en_o, stall_pc_o, stall_if_id_o, flush_if_id_o,
                        flush_id_ex_o, state_o}, {25'h0, exp_ctl});
    chk({tag, ".addr"}, jump_addr_o, exp_addr);
    chk({tag, ".cnt"}, {16'h0, flush_cnt_o}, {16'h0, exp_cnt});
    $display("step %-12s ctl=%b addr=%h cnt=%0d", tag,
             {jump_en_o, stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o, state_o},
             jump_addr_o, flush_cnt_o);
    @(posedge clk);
`ifdef PERF_CNT_EN
    if (exp_ctl[6] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
    #1;
  endtask

  task automatic in(input logic j, input logic [31:0] a, input logic h);
    jump_en_i = j; jump_addr_i = a; hold_req_i = h;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    exp_cnt = 16'h0;
    @(negedge clk);
    chk("rst.ctl", {25'h0, jump_en_o, stall_pc_o, stall_if_id_o, flush_if_id_o,
                    flush_id_ex_o, state_o}, {25'h0, 7'b0101100});
    chk("rst.addr", jump_addr_o, 32'h0);
    chk("rst.cnt", {16'h0, flush_cnt_o}, 32'h0);
    $display("reset ctl checked");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    in(1'b0, 32'h0, 1'b0);
    id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0; ex_rd_addr_i = 5'd0; ex_reg_wen_i = 1'b0;
    #1;
    reset_pulse();
    step("init",       7'b0101100, 32'h0);
    step("run",        7'b0000001, 32'h0);

    // Plain jump, then the one-cycle FLUSH bubble.
    in(1'b1, 32'h40, 1'b0);
    step("jump40",     7'b1001101, 32'h40);
    in(1'b0, 32'hDEAD, 1'b0);
    step("flush",      7'b0001010, 32'h0);
    step("run2",       7'b0000001, 32'h0);

    // Jump arriving during a hold is deferred until hold falls.
    in(1'b0, 32'h0, 1'b1);
    step("hold1",      7'b0110101, 32'h0);
    in(1'b1, 32'h80, 1'b1);
    step("hold2_j",    7'b0110111, 32'h0);
    in(1'b0, 32'h0, 1'b1);
    step("hold3",      7'b0110111, 32'h0);
    in(1'b0, 32'h0, 1'b0);
    step("hold_fall",  7'b1001111, 32'h80);
    step("flush2",     7'b0001010, 32'h0);
    step("run3",       7'b0000001, 32'h0);

    // First pending jump wins over later ones, including a live one on release.
    in(1'b0, 32'h0, 1'b1);
    step("h_a",        7'b0110101, 32'h0);
    in(1'b1, 32'h100, 1'b1);
    step("h_j1",       7'b0110111, 32'h0);
    in(1'b1, 32'h200, 1'b1);
    step("h_j2",       7'b0110111, 32'h0);
    in(1'b1, 32'h300, 1'b0);
    step("h_fall1st",  7'b1001111, 32'h100);
    in(1'b0, 32'h0, 1'b0);
    step("flush3",     7'b0001010, 32'h0);

    // Live jump in the release cycle with nothing pending.
    in(1'b0, 32'h0, 1'b1);
    step("h_b",        7'b0110101, 32'h0);
    in(1'b1, 32'h444, 1'b0);
    step("h_fall_live", 7'b1001111, 32'h444);
    in(1'b0, 32'h0, 1'b0);
    step("flush4",     7'b0001010, 32'h0);

    // Hold release with no jump returns to RUN without stalling.
    in(1'b0, 32'h0, 1'b1);
    step("h_c",        7'b0110101, 32'h0);
    in(1'b0, 32'h0, 1'b0);
    step("h_fall_nj",  7'b0000011, 32'h0);
    step("run4",       7'b0000001, 32'h0);

    // Hazards.
    ex_reg_wen_i = 1'b1; ex_rd_addr_i = 5'd5; id_rs2_addr_i = 5'd5; id_rs1_addr_i = 5'd1;
    step("haz_rs2",    7'b0110101, 32'h0);
    ex_rd_addr_i = 5'd0; id_rs2_addr_i = 5'd0; id_rs1_addr_i = 5'd0;
    step("haz_x0",     7'b0000001, 32'h0);
    ex_rd_addr_i = 5'd9; id_rs1_addr_i = 5'd9; id_rs2_addr_i = 5'd3;
    step("haz_rs1",    7'b0110101, 32'h0);
    ex_reg_wen_i = 1'b0;
    step("haz_nowen",  7'b0000001, 32'h0);
    ex_reg_wen_i = 1'b1;
    in(1'b0, 32'h0, 1'b1);
    step("hold>haz",   7'b0110101, 32'h0);
    in(1'b0, 32'h0, 1'b0);
    step("haz_in_hold_fall", 7'b0000011, 32'h0);
    in(1'b1, 32'h55C, 1'b0);
    step("jump>haz",   7'b1001101, 32'h55C);
    ex_reg_wen_i = 1'b0; ex_rd_addr_i = 5'd0; id_rs1_addr_i = 5'd0;
    in(1'b0, 32'h0, 1'b0);
    step("flush5",     7'b0001010, 32'h0);

    // Jump and hold together: jump first, FLUSH with hold, then HOLD.
    in(1'b1, 32'h600, 1'b1);
    step("j+h",        7'b1001101, 32'h600);
    in(1'b0, 32'h0, 1'b1);
    step("flush_hold", 7'b0101110, 32'h0);
    in(1'b0, 32'h0, 1'b0);
    step("j+h_fall",   7'b0000011, 32'h0);

    // Back-to-back jumps, the second taken from FLUSH.
    in(1'b1, 32'h700, 1'b0);
    step("jj1",        7'b1001101, 32'h700);
    in(1'b1, 32'h704, 1'b0);
    step("jj2",        7'b1001110, 32'h704);
    in(1'b0, 32'h0, 1'b0);
    step("flush6",     7'b0001010, 32'h0);

    // Reset mid-HOLD must discard the pending jump.
    in(1'b0, 32'h0, 1'b1);
    step("h_d",        7'b0110101, 32'h0);
    in(1'b1, 32'hAA0, 1'b1);
    step("h_d_j",      7'b0110111, 32'h0);
    reset_pulse();
    in(1'b0, 32'h0, 1'b1);
    step("init2",      7'b0101100, 32'h0);
    step("h_e",        7'b0110101, 32'h0);
    in(1'b0, 32'h0, 1'b0);
    step("h_e_fall",   7'b0000011, 32'h0);

`ifdef PERF_CNT_EN
    // Saturation of the jump-flush counter.
    in(1'b1, 32'h4, 1'b0);
    for (int i = 0; i < 65537; i++) @(posedge clk);
    #1;
    chk("cnt_sat", {16'h0, flush_cnt_o}, 32'h0000FFFF);
    $display("step cnt_sat      cnt=%0d", flush_cnt_o);
    in(1'b0, 32'h0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
